// File: rtl/lm07_spi_master_pkg.sv
// Shared definitions for the LM07 SPI read master: state encoding,
// frame geometry and the temperature-field extraction helper.
package lm07_spi_pkg;

  localparam int FRAME_BITS_DEF = 16;
  localparam int TEMP_LSB_SHIFT = 3;
  localparam int TEMP_W         = 13;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  // Upper 13 bits of the raw frame: two's-complement, 0.0625 C per LSB.
  function automatic logic [TEMP_W-1:0] temp_field(input logic [FRAME_BITS_DEF-1:0] word);
    return word[FRAME_BITS_DEF-1:TEMP_LSB_SHIFT];
  endfunction

endpackage

// File: rtl/lm07_spi_master_if.sv
// System-side handshake and result bus of the LM07 read master.
// master = system control logic, slave = the SPI read engine.
interface lm07_spi_master_if;
  import lm07_spi_pkg::*;

  logic                      start;
  logic                      busy;
  logic                      done;
  logic [FRAME_BITS_DEF-1:0] temp_data;
  logic [TEMP_W-1:0]         temp_c;
  logic                      temp_valid;

  modport master (
    output start,
    input  busy, done, temp_data, temp_c, temp_valid
  );

  modport slave (
    input  start,
    output busy, done, temp_data, temp_c, temp_valid
  );

endinterface

// File: rtl/lm07_spi_master_sync_2ff.sv
// Two-flop synchronizer for the asynchronous sensor data line.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Double-register the input to settle metastability before use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/lm07_spi_master.sv
// LM07 SPI read master: one 16-bit MSB-first read frame per start request.
// SIO is sampled at the end of each SCK-high phase; the sensor only moves
// SIO on falling SCK, so the synchronized value is stable by then.
module lm07_spi_master
  import lm07_spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  lm07_spi_master_if.slave    sys,
  output logic                CS,
  output logic                SCK,
  input  logic                SIO
);

  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BC_W = $clog2(FRAME_BITS + 1);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_BITS);
  localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] SETUP = ST_SETUP;
  localparam logic [2:0] LOW   = ST_LOW;
  localparam logic [2:0] HIGH  = ST_HIGH;
  localparam logic [2:0] HOLD  = ST_HOLD;
  localparam logic [2:0] GAP   = ST_GAP;

  logic [2:0]            state_r;
  logic [PH_W-1:0]       phase_r;
  logic [BC_W-1:0]       bit_cnt_r;
  logic [FRAME_BITS-1:0] shift_r;
  logic                  cs_r;
  logic                  sck_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  valid_r;
  logic [FRAME_BITS-1:0] temp_data_r;
  logic [TEMP_W-1:0]     temp_c_r;
  logic                  sio_sync_s;
  logic                  phase_end_s;

  sync_2ff u_sio_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (SIO),
    .q     (sio_sync_s)
  );

  assign phase_end_s = (phase_r == PH_LAST);

  // Frame sequencer: phase counter, bit counter, shifter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      phase_r     <= '0;
      bit_cnt_r   <= '0;
      shift_r     <= '0;
      cs_r        <= 1'b1;
      sck_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      valid_r     <= 1'b0;
      temp_data_r <= '0;
      temp_c_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cs_r    <= 1'b1;
          sck_r   <= 1'b0;
          phase_r <= '0;
          if (sys.start) begin
            state_r   <= SETUP;
            cs_r      <= 1'b0;
            busy_r    <= 1'b1;
            bit_cnt_r <= '0;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        SETUP: begin
          if (phase_end_s) begin
            phase_r <= '0;
            state_r <= LOW;
          end else begin
            phase_r <= phase_r + PH_W'(1);
          end
        end
        LOW: begin
          if (phase_end_s) begin
            phase_r <= '0;
            sck_r   <= 1'b1;
            state_r <= HIGH;
          end else begin
            phase_r <= phase_r + PH_W'(1);
          end
        end
        HIGH: begin
          if (phase_end_s) begin
            phase_r   <= '0;
            sck_r     <= 1'b0;
            shift_r   <= {shift_r[FRAME_BITS-2:0], sio_sync_s};
            bit_cnt_r <= bit_cnt_r + BC_ONE;
            if ((bit_cnt_r + BC_ONE) == BC_LAST) begin
              state_r <= HOLD;
            end else begin
              state_r <= LOW;
            end
          end else begin
            phase_r <= phase_r + PH_W'(1);
          end
        end
        HOLD: begin
          if (phase_end_s) begin
            phase_r     <= '0;
            cs_r        <= 1'b1;
            done_r      <= 1'b1;
            temp_data_r <= shift_r;
            temp_c_r    <= temp_field(shift_r);
            valid_r     <= 1'b1;
            state_r     <= GAP;
          end else begin
            phase_r <= phase_r + PH_W'(1);
          end
        end
        GAP: begin
          if (phase_end_s) begin
            phase_r <= '0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            phase_r <= phase_r + PH_W'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          phase_r   <= '0;
          bit_cnt_r <= '0;
          cs_r      <= 1'b1;
          sck_r     <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign CS             = cs_r;
  assign SCK            = sck_r;
  assign sys.busy       = busy_r;
  assign sys.done       = done_r;
  assign sys.temp_data  = temp_data_r;
  assign sys.temp_c     = temp_c_r;
  assign sys.temp_valid = valid_r;

endmodule

// File: tb/tb_lm07_spi_master.sv
// Bench for the LM07 SPI read master: a behavioural LM07 sensor, a
// frame/timing monitor and a scoreboard of expected words.
module tb_lm07_spi_master;
  import lm07_spi_pkg::*;

  localparam int CD     = 4;
  localparam int FB     = 16;
  localparam int CS_LOW = CD * (2 * FB + 2);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic CS;
  logic SCK;
  logic SIO   = 1'b0;

  lm07_spi_master_if sys_if();

  lm07_spi_master #(.CLK_DIV(CD), .FRAME_BITS(FB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sys   (sys_if),
    .CS    (CS),
    .SCK   (SCK),
    .SIO   (SIO)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Sensor model: latches its word when CS falls, presents the MSB, then
  // moves to the next bit on every falling SCK while selected.
  logic [15:0] sensor_word = 16'h0000;
  logic [15:0] tx_word     = 16'h0000;
  int          tx_idx      = 0;
  logic        sens_cs     = 1'b1;
  logic [15:0] exp_q[$];

  // Behavioural LM07 serial output.
  always @(posedge CS or negedge CS or negedge SCK) begin
    if (!CS && sens_cs) begin
      tx_word = sensor_word;
      tx_idx  = FB - 1;
      SIO     = tx_word[FB-1];
      if (rst_n) exp_q.push_back(tx_word);
    end else if (!CS && tx_idx > 0) begin
      tx_idx = tx_idx - 1;
      SIO    = tx_word[tx_idx];
    end
    sens_cs = CS;
  end

  // Monitor state.
  logic cs_prev   = 1'b1;
  logic sck_prev  = 1'b0;
  logic done_prev = 1'b0;
  bit   in_frame  = 1'b0;
  bit   have_prev = 1'b0;
  bit   b2b       = 1'b0;
  int   low_cnt   = 0;
  int   high_cnt  = 0;
  int   rises     = 0;
  int   done_cnt  = 0;
  int   gap_checks = 0;

  // Monitor: frame timing, done pulses and scoreboard comparison.
  always @(negedge clk) begin
    logic [15:0] w;
    int          t;
    if (!rst_n) begin
      in_frame  = 1'b0;
      cs_prev   = 1'b1;
      sck_prev  = 1'b0;
      done_prev = 1'b0;
      rises     = 0;
      exp_q.delete();
    end else begin
      if (!CS) begin
        if (cs_prev) begin
          if (b2b && have_prev) begin
            check("cs_high_gap", 32'(high_cnt), 32'(CD + 1));
            gap_checks++;
          end
          in_frame = 1'b1;
          low_cnt  = 1;
          rises    = 0;
        end else begin
          low_cnt++;
        end
      end else begin
        if (!cs_prev) begin
          if (in_frame) begin
            check("cs_low_cycles", 32'(low_cnt), 32'(CS_LOW));
            check("sck_rises", 32'(rises), 32'(FB));
          end
          in_frame  = 1'b0;
          have_prev = b2b;
          high_cnt  = 1;
        end else begin
          high_cnt++;
        end
      end
      if (SCK && !sck_prev) rises++;
      if (sys_if.done) begin
        done_cnt++;
        check("done_one_cycle", 32'(done_prev), 32'd0);
        check("done_with_cs_high", 32'(CS), 32'd1);
        check("busy_at_done", 32'(sys_if.busy), 32'd1);
        check("temp_valid", 32'(sys_if.temp_valid), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=%0h required=none", sys_if.temp_data);
        end else begin
          w = exp_q.pop_front();
          t = $signed(w) >>> TEMP_LSB_SHIFT;
          check("temp_data", 32'(sys_if.temp_data), 32'(w));
          check("temp_c", 32'(sys_if.temp_c), 32'(t & 32'h1FFF));
        end
      end
      cs_prev   = CS;
      sck_prev  = SCK;
      done_prev = sys_if.done;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    sys_if.start = 1'b1;
    @(negedge clk);
    sys_if.start = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] w);
    int d0;
    int t;
    sensor_word = w;
    d0 = done_cnt;
    pulse_start();
    t = 0;
    while (done_cnt == d0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL frame_timeout actual=no_done required=done");
    end
    repeat (CD + 2) @(negedge clk);
    check("busy_idle", 32'(sys_if.busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"}, 32'(CS), 32'd1);
    check({tag, "_sck"}, 32'(SCK), 32'd0);
    check({tag, "_busy"}, 32'(sys_if.busy), 32'd0);
    check({tag, "_done"}, 32'(sys_if.done), 32'd0);
    check({tag, "_valid"}, 32'(sys_if.temp_valid), 32'd0);
    check({tag, "_data"}, 32'(sys_if.temp_data), 32'h0);
    check({tag, "_tempc"}, 32'(sys_if.temp_c), 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int g0;
    int t;
    sys_if.start = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal positive reading (98 C).
    run_frame(16'h3100);
    check("nominal_data", 32'(sys_if.temp_data), 32'h3100);
    check("nominal_tempc", 32'(sys_if.temp_c), 32'h0620);

    // Negative reading (-1 C); values hold while idle.
    run_frame(16'hFF80);
    repeat (10) @(negedge clk);
    check("neg_data_hold", 32'(sys_if.temp_data), 32'hFF80);
    check("neg_tempc_hold", 32'(sys_if.temp_c), 32'h1FF0);

    // Start pulses 10 cycles into the frame and during GAP are ignored.
    sensor_word = 16'h3100;
    d0 = done_cnt;
    pulse_start();
    repeat (9) @(negedge clk);
    sys_if.start = 1'b1;
    @(negedge clk);
    sys_if.start = 1'b0;
    repeat (127) @(negedge clk);
    sys_if.start = 1'b1;
    @(negedge clk);
    sys_if.start = 1'b0;
    repeat (40) @(negedge clk);
    check("reject_done_count", 32'(done_cnt - d0), 32'd1);
    check("reject_cs_idle", 32'(CS), 32'd1);
    check("reject_busy_idle", 32'(sys_if.busy), 32'd0);

    // Random words with random idle spacing.
    for (int i = 0; i < 8; i++) begin
      run_frame(16'($urandom));
      repeat ($urandom_range(0, 15)) @(negedge clk);
    end

    // Reset after the 7th SCK rising edge aborts the frame.
    sensor_word = 16'h1234;
    pulse_start();
    t = 0;
    while (rises < 7 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("abort_reached_edge7", 32'(rises >= 7), 32'd1);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    repeat (2) @(negedge clk);
    run_frame(16'h3100);
    check("after_abort_data", 32'(sys_if.temp_data), 32'h3100);

    // Back-to-back frames with start held high.
    sensor_word = 16'h3100;
    b2b = 1'b1;
    d0 = done_cnt;
    g0 = gap_checks;
    @(negedge clk);
    sys_if.start = 1'b1;
    t = 0;
    while (done_cnt < d0 + 3 && t < 700) begin
      @(negedge clk);
      t++;
    end
    sys_if.start = 1'b0;
    repeat (CD + 6) @(negedge clk);
    b2b = 1'b0;
    check("b2b_done_count", 32'(done_cnt - d0), 32'd3);
    check("b2b_gap_checks", 32'(gap_checks - g0), 32'd2);
    check("b2b_cs_idle", 32'(CS), 32'd1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lm07_spi_master.md
Name: lm07_spi_master

Overview:
- SPI read master for the LM07 temperature sensor; drives CS and SCK and samples SIO, which is the sensor's serial data output.
- On each start request it performs one 16-bit read frame, MSB first.
- It returns the raw word and the sign-extended 13-bit temperature field to the system side.
- Sits between the system control logic (upstream) and the off-chip LM07 sensor (downstream).

Parameters:
- CLK_DIV, 4: clk cycles per SCK phase (low or high). Legal values are ≥2. SCK period = 2*CLK_DIV clk cycles.
- FRAME_BITS, 16: bits per read frame. Fixed at 16 for the LM07; the parameter exists only for the bench.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a read frame; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted until the return to IDLE
- done  output  1  one-cycle pulse; temp_data and temp_c are updated in the same cycle
- temp_data  output  16  raw frame, first received bit in [15]
- temp_c  output  13  temp_data[15:3], signed, 0.0625 °C/LSB
- temp_valid  output  1  sticky; set on the first done, cleared only by reset
- CS  output  1  sensor chip select, active low
- SCK  output  1  serial clock, idle low
- SIO  input  1  sensor serial data

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - CS=1, SCK=0, busy=0, done=0, temp_valid=0.
  - temp_data=0, temp_c=0.
  - State returns to IDLE; bit and phase counters clear.
- All outputs are registered. SIO passes through a 2-flop synchronizer before use.
- States: IDLE, SETUP, LOW, HIGH, HOLD, GAP.
- IDLE:
  - CS=1, SCK=0.
  - start=1 → SETUP next cycle, with CS=0 and busy=1.
- SETUP: CS low for CLK_DIV cycles with SCK low; the sensor presents bit 15 on SIO during this time. → LOW.
- LOW: SCK=0 for CLK_DIV cycles. → HIGH, with SCK=1.
- HIGH:
  - SCK=1 for CLK_DIV cycles.
  - In the last HIGH cycle, shift the synchronized SIO into shift_reg[0] (left shift). This is valid because the sensor only changes SIO on SCK falling edges, so data is stable for 2*CLK_DIV cycles.
  - Then SCK=0 and bit_cnt increments.
  - bit_cnt < FRAME_BITS → LOW. bit_cnt == FRAME_BITS → HOLD.
- HOLD:
  - SCK=0, CS=0 for CLK_DIV cycles.
  - Then CS=1, done=1 for one cycle, temp_data ← shift_reg, temp_c ← shift_reg[15:3], temp_valid=1. → GAP.
- GAP:
  - CS high, busy high, for CLK_DIV cycles. This is the minimum CS-high time and also forces the sensor's reload.
  - Then busy=0 → IDLE.
- Frame timing: CS low for exactly CLK_DIV*(2*FRAME_BITS+2) cycles (136 at defaults); exactly FRAME_BITS SCK rising edges per frame.
- start while busy is ignored; requests are not queued.
- start held high continuously gives back-to-back frames, each separated by CLK_DIV+1 CS-high cycles (GAP plus the IDLE accept cycle).
- temp_data and temp_c hold their value between frames; an aborted frame (reset) never updates them.
- SIO is never driven by this block.

Decomposition:
- Package lm07_spi_pkg holds:
  - state enum: IDLE, SETUP, LOW, HIGH, HOLD, GAP
  - FRAME_BITS_DEF=16
  - TEMP_LSB_SHIFT=3
  - TEMP_W=13
- One sub-module, sync_2ff: a 2-flop synchronizer for SIO with async active-low reset to 0.
- The phase counter, bit counter and FSM stay in the top module.

Test Plan:
- Reset values: assert rst_n=0 mid-simulation → CS=1, SCK=0, busy=0, done=0, temp_valid=0, temp_data=16'h0000 within the same time step, with no clk edge needed.
- Nominal read: sensor model loaded with 16'h3100, CLK_DIV=4, pulse start → CS low for 136 clk, 16 SCK rising edges, done pulse lasting one cycle, temp_data=16'h3100, temp_c=13'h0620 (98 °C), temp_valid=1.
- Negative temperature: sensor loaded with 16'hFF80 → temp_data=16'hFF80, temp_c=13'h1FF0 (−1 °C).
- Busy rejection: pulse start again 10 cycles into a frame and during GAP → no extra frame, CS stays low for exactly 136 cycles, exactly one done.
- Reset mid-frame: deassert rst_n after the 7th SCK rising edge → CS=1, SCK=0 immediately, no done, temp_valid=0. After release, a new start returns the full correct word 16'h3100.
- Back-to-back: hold start=1 for 3 frames → 3 done pulses, CS high for exactly CLK_DIV+1 (5) cycles between frames, all three frames equal to 16'h3100.
